// File: rtl/tail_emitter.sv
// tail_emitter: serialises one instruction (header nibble + up to four tail
// nibbles of an immediate) into a nibble stream with valid/ready handshakes.
// Literal mode picks the shortest header that still sign-extends the value;
// raw mode uses the supplied header and its tail length from the shared table.
module tail_emitter #(
    parameter bit LSN_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_lit,
    input  logic [3:0]  in_hdr,
    input  logic [15:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_nib,
    output logic        out_last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t      state_reg;
    logic [15:0] imm_reg;
    logic [2:0]  n_reg;
    logic [1:0]  cnt_reg;
    logic        in_ready_reg;
    logic        out_valid_reg;
    logic [3:0]  out_nib_reg;
    logic        out_last_reg;

    logic [3:0]  sel_hdr;
    logic [2:0]  sel_n;
    logic [3:0]  nib_arr [4];
    logic [1:0]  first_idx;
    logic [1:0]  next_idx;
    logic [3:0]  first_nib;
    logic [3:0]  next_nib;

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_nib   = out_nib_reg;
    assign out_last  = out_last_reg;

    // Tail length decode shared with the fetch side; unused codes carry no tail.
    function automatic logic [2:0] tail_len(input logic [3:0] h);
        logic [2:0] len;
        if (h[1:0] == 2'b00) begin
            len = 3'd1;
        end else if (h[3] && !h[1]) begin
            len = 3'd1;
        end else begin
            case (h)
                4'b0001: len = 3'd2;
                4'b0010: len = 3'd3;
                4'b0011: len = 3'd4;
                default: len = 3'd0;
            endcase
        end
        return len;
    endfunction

    // Map a tail position to the immediate nibble it carries, honouring order.
    function automatic logic [1:0] nib_index(input logic [2:0] n, input logic [1:0] pos);
        logic [1:0] k;
        if (LSN_FIRST) begin
            k = pos;
        end else begin
            // n in 1..4: (n-1-pos) mod 4 is exact because n=4 wraps to 0.
            k = n[1:0] - 2'd1 - pos;
        end
        return k;
    endfunction

    // Split the latched immediate into its four nibbles.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nib
            assign nib_arr[gi] = imm_reg[4*gi +: 4];
        end
    endgenerate

    // Choose header and tail length for the offered instruction.
    always_comb begin
        sel_hdr = in_hdr;
        sel_n   = tail_len(in_hdr);
        if (in_lit) begin
            if ((&in_imm[15:3]) || !(|in_imm[15:3])) begin
                sel_hdr = 4'b0000;
                sel_n   = 3'd1;
            end else if ((&in_imm[15:7]) || !(|in_imm[15:7])) begin
                sel_hdr = 4'b0001;
                sel_n   = 3'd2;
            end else if ((&in_imm[15:11]) || !(|in_imm[15:11])) begin
                sel_hdr = 4'b0010;
                sel_n   = 3'd3;
            end else begin
                sel_hdr = 4'b0011;
                sel_n   = 3'd4;
            end
        end
    end

    // Nibbles for the first tail slot and for the slot after the current one.
    always_comb begin
        first_idx = nib_index(n_reg, 2'd0);
        next_idx  = nib_index(n_reg, cnt_reg + 2'd1);
        first_nib = nib_arr[first_idx];
        next_nib  = nib_arr[next_idx];
    end

    // Control FSM with all handshake and stream outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            imm_reg       <= '0;
            n_reg         <= '0;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_nib_reg   <= '0;
            out_last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        imm_reg       <= in_imm;
                        n_reg         <= sel_n;
                        cnt_reg       <= '0;
                        in_ready_reg  <= 1'b0;
                        out_valid_reg <= 1'b1;
                        out_nib_reg   <= sel_hdr;
                        out_last_reg  <= (sel_n == 3'd0);
                        state_reg     <= HDR;
                    end
                end
                HDR: begin
                    if (out_ready) begin
                        if (n_reg == 3'd0) begin
                            in_ready_reg  <= 1'b1;
                            out_valid_reg <= 1'b0;
                            out_nib_reg   <= '0;
                            out_last_reg  <= 1'b0;
                            state_reg     <= IDLE;
                        end else begin
                            cnt_reg      <= '0;
                            out_nib_reg  <= first_nib;
                            out_last_reg <= (n_reg == 3'd1);
                            state_reg    <= TAIL;
                        end
                    end
                end
                TAIL: begin
                    if (out_ready) begin
                        if (({1'b0, cnt_reg} + 3'd1) == n_reg) begin
                            cnt_reg       <= '0;
                            in_ready_reg  <= 1'b1;
                            out_valid_reg <= 1'b0;
                            out_nib_reg   <= '0;
                            out_last_reg  <= 1'b0;
                            state_reg     <= IDLE;
                        end else begin
                            cnt_reg      <= cnt_reg + 2'd1;
                            out_nib_reg  <= next_nib;
                            out_last_reg <= (({1'b0, cnt_reg} + 3'd2) == n_reg);
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    out_nib_reg   <= '0;
                    out_last_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tail_emitter.sv
// Directed bench for tail_emitter: two instances (LSN-first and MSN-first)
// share the same stimulus; a vector table covers literal/raw encodings and
// hand-written sequences cover backpressure and mid-tail reset.
module tb_tail_emitter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_lit;
    logic [3:0]  in_hdr;
    logic [15:0] in_imm;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_last_a;
    logic [3:0]  out_nib_a;
    logic        in_ready_b, out_valid_b, out_last_b;
    logic [3:0]  out_nib_b;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic            lit;
        logic [3:0]      hdr;
        logic [15:0]     imm;
        logic [2:0]      n;
        logic [3:0]      hnib;
        logic [3:0][3:0] tail;   // tail[j] = j-th nibble in LSN-first order
    } vec_t;

    vec_t vecs [11];

    always #5 clk = ~clk;

    tail_emitter #(.LSN_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_lit(in_lit), .in_hdr(in_hdr), .in_imm(in_imm),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_nib(out_nib_a), .out_last(out_last_a)
    );

    tail_emitter #(.LSN_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_lit(in_lit), .in_hdr(in_hdr), .in_imm(in_imm),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_nib(out_nib_b), .out_last(out_last_b)
    );

    function automatic vec_t mk(input logic lit, input logic [3:0] hdr, input logic [15:0] imm,
                                input logic [2:0] n, input logic [3:0] hn,
                                input logic [3:0] t0, input logic [3:0] t1,
                                input logic [3:0] t2, input logic [3:0] t3);
        vec_t v;
        v.lit  = lit;
        v.hdr  = hdr;
        v.imm  = imm;
        v.n    = n;
        v.hnib = hn;
        v.tail = {t3, t2, t1, t0};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Both instances must present the same valid/last and the given nibbles.
    task automatic chk_out(input string name, input logic [3:0] nib_a, input logic [3:0] nib_b,
                           input logic last);
        chk({name, "_valid"}, {out_valid_a, out_valid_b}, 2'b11);
        chk({name, "_nib_lsn"}, out_nib_a, nib_a);
        chk({name, "_nib_msn"}, out_nib_b, nib_b);
        chk({name, "_last"}, {out_last_a, out_last_b}, {last, last});
    endtask

    // Offer one instruction with the sink always ready and check every nibble.
    task automatic send(input vec_t v, input int id);
        int waited = 0;
        in_lit    = v.lit;
        in_hdr    = v.hdr;
        in_imm    = v.imm;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (!(in_ready_a && in_ready_b) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_ready", {in_ready_a, in_ready_b}, 2'b11);
        @(negedge clk);
        in_valid = 1'b0;
        chk_out("hdr", v.hnib, v.hnib, (v.n == 3'd0));
        chk("busy_ready", {in_ready_a, in_ready_b}, 2'b00);
        for (int j = 0; j < int'(v.n); j++) begin
            @(negedge clk);
            chk_out("tail", v.tail[j], v.tail[int'(v.n) - 1 - j], (j == int'(v.n) - 1));
        end
        @(negedge clk);
        chk("end_valid", {out_valid_a, out_valid_b}, 2'b00);
        chk("end_ready", {in_ready_a, in_ready_b}, 2'b11);
        $display("txn %0d lit=%0b hdr=%h imm=%h n=%0d", id, v.lit, v.hdr, v.imm, v.n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = mk(1'b1, 4'h0, 16'h0005, 3'd1, 4'h0, 4'h5, 4'h0, 4'h0, 4'h0);
        vecs[1]  = mk(1'b1, 4'h0, 16'hFFF8, 3'd1, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0);
        vecs[2]  = mk(1'b1, 4'h0, 16'h0008, 3'd2, 4'h1, 4'h8, 4'h0, 4'h0, 4'h0);
        vecs[3]  = mk(1'b1, 4'h0, 16'h1234, 3'd4, 4'h3, 4'h4, 4'h3, 4'h2, 4'h1);
        vecs[4]  = mk(1'b0, 4'hF, 16'h1234, 3'd0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[5]  = mk(1'b0, 4'h9, 16'h00A7, 3'd1, 4'h9, 4'h7, 4'h0, 4'h0, 4'h0);
        vecs[6]  = mk(1'b0, 4'h2, 16'hABCD, 3'd3, 4'h2, 4'hD, 4'hC, 4'hB, 4'h0);
        vecs[7]  = mk(1'b0, 4'hC, 16'h1235, 3'd1, 4'hC, 4'h5, 4'h0, 4'h0, 4'h0);
        vecs[8]  = mk(1'b1, 4'h7, 16'hFF80, 3'd2, 4'h1, 4'h0, 4'h8, 4'h0, 4'h0);
        vecs[9]  = mk(1'b1, 4'h0, 16'h8000, 3'd4, 4'h3, 4'h0, 4'h0, 4'h0, 4'h8);
        vecs[10] = mk(1'b0, 4'h1, 16'hFFEE, 3'd2, 4'h1, 4'hE, 4'hE, 4'h0, 4'h0);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_lit    = 1'b0;
        in_hdr    = 4'h0;
        in_imm    = 16'h0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", {out_valid_a, out_valid_b}, 2'b00);
        chk("rst_nib", {out_nib_a, out_nib_b}, 8'h00);
        chk("rst_last", {out_last_a, out_last_b}, 2'b00);
        chk("rst_ready", {in_ready_a, in_ready_b}, 2'b11);

        for (int i = 0; i < 11; i++) begin
            send(vecs[i], i);
        end

        // Backpressure: stall 3 cycles on the first tail nibble of lit 0x1234.
        in_lit = 1'b1; in_hdr = 4'h0; in_imm = 16'h1234; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk_out("bp_hdr", 4'h3, 4'h3, 1'b0);
        @(negedge clk);
        chk_out("bp_t0", 4'h4, 4'h1, 1'b0);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_out("bp_hold", 4'h4, 4'h1, 1'b0);
            chk("bp_busy", {in_ready_a, in_ready_b}, 2'b00);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk_out("bp_t1", 4'h3, 4'h2, 1'b0);
        @(negedge clk);
        chk_out("bp_t2", 4'h2, 4'h3, 1'b0);
        chk("bp_busy2", {in_ready_a, in_ready_b}, 2'b00);
        @(negedge clk);
        chk_out("bp_t3", 4'h1, 4'h4, 1'b1);
        @(negedge clk);
        chk("bp_end_valid", {out_valid_a, out_valid_b}, 2'b00);
        chk("bp_end_ready", {in_ready_a, in_ready_b}, 2'b11);
        $display("txn bp lit=1 imm=1234 stalled 3 cycles");

        // Reset while the second tail nibble is presented.
        in_lit = 1'b1; in_imm = 16'h1234; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk_out("rs_hdr", 4'h3, 4'h3, 1'b0);
        @(negedge clk);
        chk_out("rs_t0", 4'h4, 4'h1, 1'b0);
        @(negedge clk);
        chk_out("rs_t1", 4'h3, 4'h2, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("rs_valid", {out_valid_a, out_valid_b}, 2'b00);
        chk("rs_nib", {out_nib_a, out_nib_b}, 8'h00);
        chk("rs_last", {out_last_a, out_last_b}, 2'b00);
        rst = 1'b0;
        @(negedge clk);
        chk("rs_ready", {in_ready_a, in_ready_b}, 2'b11);
        chk("rs_idle", {out_valid_a, out_valid_b}, 2'b00);
        $display("txn rst mid-tail lit=1 imm=1234 dropped");
        send(mk(1'b1, 4'h0, 16'h0001, 3'd1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0), 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
